// File: rtl/dsram_post.sv
// Data-SRAM memory-access stage: latches a prepared load/store, runs it over an
// AXI4-Lite master port, aligns/extends load data and hands the result to write-back.
module dsram_post (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_pre_i,
    output logic        ready_pre_o,
    input  logic [1:0]  inst_type_i,
    input  logic [3:0]  lsu_op_i,
    input  logic [31:0] araddr_i,
    input  logic [31:0] roff_i,
    input  logic [31:0] awaddr_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    output logic        valid_post_o,
    input  logic        ready_post_i,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 8;

    localparam logic [1:0] INST_LOAD  = 2'd1;
    localparam logic [1:0] INST_STORE = 2'd2;

    localparam logic [3:0] LSU_LB  = 4'd1;
    localparam logic [3:0] LSU_LH  = 4'd2;
    localparam logic [3:0] LSU_LW  = 4'd3;
    localparam logic [3:0] LSU_LBU = 4'd4;
    localparam logic [3:0] LSU_LHU = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [DW-1:0]   araddr_q, araddr_d;
    logic [1:0]      roff_q, roff_d;
    logic [DW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic            err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [DW-1:0]   rd_shift;
    logic [DW-1:0]   rd_ext;
    logic            unused_ok;

    assign unused_ok = ^roff_i[31:2];

    // Byte-align the returned word and extend according to the latched op.
    always_comb begin
        rd_shift = rdata >> {roff_q, 3'b000};
        rd_ext   = '0;
        case (op_q)
            LSU_LB:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            LSU_LBU: rd_ext = {24'd0, rd_shift[7:0]};
            LSU_LH:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            LSU_LHU: rd_ext = {16'd0, rd_shift[15:0]};
            LSU_LW:  rd_ext = rd_shift;
            default: rd_ext = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        araddr_d  = araddr_q;
        roff_d    = roff_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        rdata_d   = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (valid_pre_i) begin
                    op_d      = lsu_op_i;
                    araddr_d  = araddr_i;
                    roff_d    = roff_i[1:0];
                    awaddr_d  = awaddr_i;
                    wdata_d   = wdata_i << {awaddr_i[1:0], 3'b000};
                    wstrb_d   = wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    rdata_d   = '0;
                    case (inst_type_i)
                        INST_LOAD:  state_d = S_AR;
                        INST_STORE: state_d = S_AW_W;
                        default:    state_d = S_DONE;
                    endcase
                end
            end
            S_AR: begin
                if (arready) state_d = S_R;
            end
            S_R: begin
                if (rvalid) begin
                    rdata_d = rd_ext;
                    err_d   = (rresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_AW_W: begin
                // Address and data channels complete independently.
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) state_d = S_B;
            end
            S_B: begin
                if (bvalid) begin
                    err_d   = (bresp != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_post_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            araddr_q  <= '0;
            roff_q    <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            araddr_q  <= araddr_d;
            roff_q    <= roff_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Handshake outputs decode from registered state only.
    assign ready_pre_o  = (state_q == S_IDLE);
    assign arvalid      = (state_q == S_AR);
    assign rready       = (state_q == S_R);
    assign awvalid      = (state_q == S_AW_W) && !aw_done_q;
    assign wvalid       = (state_q == S_AW_W) && !w_done_q;
    assign bready       = (state_q == S_B);
    assign valid_post_o = (state_q == S_DONE);

    assign araddr  = araddr_q;
    assign awaddr  = awaddr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dsram_post.sv
// Directed bench for dsram_post: drives an AXI4-Lite slave by hand and checks
// results against a spec-level load/store model plus literal expectations.
module tb_dsram_post;

    localparam logic [1:0] INST_OTHER = 2'd0;
    localparam logic [1:0] INST_LOAD  = 2'd1;
    localparam logic [1:0] INST_STORE = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_OTHER = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_pre_i = 1'b0;
    logic        ready_pre_o;
    logic [1:0]  inst_type_i = '0;
    logic [3:0]  lsu_op_i = '0;
    logic [31:0] araddr_i = '0, roff_i = '0, awaddr_i = '0, wdata_i = '0;
    logic [7:0]  wstrb_i = '0;
    logic        valid_post_o;
    logic        ready_post_i = 1'b0;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;

    dsram_post dut (
        .clk(clk), .rst(rst),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
        .inst_type_i(inst_type_i), .lsu_op_i(lsu_op_i),
        .araddr_i(araddr_i), .roff_i(roff_i), .awaddr_i(awaddr_i), .wdata_i(wdata_i),
        .wstrb_i(wstrb_i),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
        .rdata_o(rdata_o), .err_o(err_o),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int t0 = 0;
    logic chk_en = 1'b0;

    int          exp_kind = K_OTHER;
    logic [31:0] exp_araddr = '0, exp_awaddr = '0, exp_wdata = '0, exp_rdata = '0;
    logic [7:0]  exp_wstrb = '0;
    logic        exp_err = 1'b0;

    // Spec-level model: byte lanes selected by offset, then extended.
    function automatic logic [31:0] load_model(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * off);
        case (op)
            OP_LB:   return 32'($signed(sh[7:0]));
            OP_LBU:  return 32'(sh[7:0]);
            OP_LH:   return 32'($signed(sh[15:0]));
            OP_LHU:  return 32'(sh[15:0]);
            OP_LW:   return sh;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_model(input logic [31:0] addr, input logic [31:0] data);
        return data << (8 * addr[1:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        check(name, 32'(act), 32'(req));
    endtask

    task automatic checki(input string name, input int act, input int req);
        check(name, 32'(act), 32'(req));
    endtask

    // Per-cycle compare against the model while outputs are meaningful.
    always @(negedge clk) begin
        if (rst && chk_en) begin
            if (arvalid) check("araddr", araddr, exp_araddr);
            if (awvalid) check("awaddr", awaddr, exp_awaddr);
            if (wvalid) begin
                check("wdata", wdata, exp_wdata);
                check("wstrb", 32'(wstrb), 32'(exp_wstrb));
            end
            if (valid_post_o) begin
                check("rdata_o", rdata_o, exp_rdata);
                check1("err_o", err_o, exp_err);
                check1("pre_post_excl", ready_pre_o, 1'b0);
            end
            if (exp_kind == K_OTHER)
                check("no_axi_valid", 32'({arvalid, awvalid, wvalid}), 32'd0);
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return arvalid;
            1:       return rready;
            2:       return awvalid;
            3:       return bready;
            default: return valid_post_o;
        endcase
    endfunction

    task automatic wait_sig(input int sel, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sig(sel)) begin
                lat = cyc - t0;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_%0d: got low for 200 cycles required high", sel);
    endtask

    task automatic accept(input logic [1:0] it, input logic [3:0] op, input logic [31:0] aa,
                          input logic [31:0] ro, input logic [31:0] wa, input logic [31:0] wd,
                          input logic [7:0] ws);
        @(negedge clk);
        inst_type_i = it;
        lsu_op_i    = op;
        araddr_i    = aa;
        roff_i      = ro;
        awaddr_i    = wa;
        wdata_i     = wd;
        wstrb_i     = ws;
        valid_pre_i = 1'b1;
        t0 = cyc;
        check1("ready_pre_o", ready_pre_o, 1'b1);
        @(posedge clk);
        #1;
        valid_pre_i = 1'b0;
        lsu_op_i    = ~lsu_op_i;
        araddr_i    = ~araddr_i;
        roff_i      = ~roff_i;
        awaddr_i    = ~awaddr_i;
        wdata_i     = ~wdata_i;
        wstrb_i     = ~wstrb_i;
    endtask

    task automatic finish_done(input int post_dly, input int lat_req, input logic [31:0] lit_rd,
                               input logic lit_err);
        int lat;
        wait_sig(4, lat);
        checki("post_latency", lat, lat_req);
        check("rdata_o_lit", rdata_o, lit_rd);
        check1("err_o_lit", err_o, lit_err);
        repeat (post_dly) begin
            @(negedge clk);
            check1("done_held", valid_post_o, 1'b1);
        end
        ready_post_i = 1'b1;
        @(posedge clk);
        #1;
        ready_post_i = 1'b0;
        @(negedge clk);
        check1("no_reaccept_post", valid_post_o, 1'b0);
        check1("idle_again", ready_pre_o, 1'b1);
    endtask

    task automatic do_load(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] ro,
                           input logic [31:0] word, input logic [1:0] rr, input int ar_dly,
                           input int r_dly, input int post_dly, input logic [31:0] lit_rd);
        int lat;
        exp_kind   = K_LOAD;
        exp_araddr = addr;
        exp_rdata  = load_model(op, ro[1:0], word);
        exp_err    = (rr != 2'b00);
        accept(INST_LOAD, op, addr, ro, 32'h0, 32'h0, 8'h0);
        wait_sig(0, lat);
        checki("ar_latency", lat, 1);
        repeat (ar_dly) begin
            @(negedge clk);
            check1("arvalid_held", arvalid, 1'b1);
        end
        arready = 1'b1;
        @(posedge clk);
        #1;
        arready = 1'b0;
        rdata = word;
        rresp = rr;
        wait_sig(1, lat);
        checki("r_latency", lat, 2 + ar_dly);
        repeat (r_dly) begin
            @(negedge clk);
            check1("rready_held", rready, 1'b1);
        end
        rvalid = 1'b1;
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        rdata  = 32'hDEAD_BEEF;
        rresp  = 2'b00;
        finish_done(post_dly, 3 + ar_dly + r_dly, lit_rd, rr != 2'b00);
    endtask

    task automatic do_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, input logic [1:0] br, input int post_dly,
                            input logic [31:0] lit_wd, input logic lit_err);
        int   lat;
        int   k;
        logic aw_hs, w_hs;
        exp_kind   = K_STORE;
        exp_awaddr = addr;
        exp_wdata  = store_model(addr, data);
        exp_wstrb  = strb;
        exp_rdata  = 32'd0;
        exp_err    = (br != 2'b00);
        accept(INST_STORE, op, 32'h0, 32'h0, addr, data, strb);
        wait_sig(2, lat);
        checki("aw_latency", lat, 1);
        check1("wvalid_with_awvalid", wvalid, 1'b1);
        check("wdata_lit", wdata, lit_wd);
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        k     = 0;
        while (!(aw_hs && w_hs) && k < 50) begin
            check1("awvalid_state", awvalid, !aw_hs);
            check1("wvalid_state", wvalid, !w_hs);
            check1("bready_early", bready, 1'b0);
            awready = (k >= aw_dly);
            wready  = (k >= w_dly);
            @(posedge clk);
            if (awready) aw_hs = 1'b1;
            if (wready)  w_hs  = 1'b1;
            #1;
            awready = 1'b0;
            wready  = 1'b0;
            @(negedge clk);
            k++;
        end
        check1("bready_in_b", bready, 1'b1);
        checki("b_latency", cyc - t0, 2 + ((aw_dly > w_dly) ? aw_dly : w_dly));
        bresp = br;
        repeat (b_dly) begin
            @(negedge clk);
            check1("bready_held", bready, 1'b1);
        end
        bvalid = 1'b1;
        @(posedge clk);
        #1;
        bvalid = 1'b0;
        bresp  = 2'b00;
        finish_done(post_dly, 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly, 32'd0, lit_err);
    endtask

    task automatic do_other();
        exp_kind  = K_OTHER;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        accept(INST_OTHER, 4'd0, 32'h1111_1111, 32'h3, 32'h2222_2222, 32'h3333_3333, 8'hFF);
        finish_done(0, 1, 32'd0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_ready_pre_o"}, ready_pre_o, 1'b1);
        check("reset_valids", 32'({arvalid, rready, awvalid, wvalid, bready, valid_post_o}), 32'd0);
        check({tag, "_rdata_o"}, rdata_o, 32'd0);
        check1({tag, "_err_o"}, err_o, 1'b0);
        check({tag, "_araddr"}, araddr, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(wstrb), 32'd0);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        chk_en = 1'b1;

        //        op      araddr        roff   rdata          rr     ar r  post lit
        do_load(OP_LB,  32'h8000_0003, 32'd3, 32'h80AB_CDEF, 2'b00, 0, 0, 0, 32'hFFFF_FF80);
        do_load(OP_LHU, 32'h8000_0102, 32'd2, 32'h1234_5678, 2'b00, 4, 0, 0, 32'h0000_1234);
        do_load(OP_LH,  32'h8000_0200, 32'd0, 32'h0000_8001, 2'b00, 0, 2, 0, 32'hFFFF_8001);
        do_load(OP_LBU, 32'h8000_0301, 32'd1, 32'h0000_F000, 2'b00, 1, 1, 0, 32'h0000_00F0);
        do_load(OP_LW,  32'h8000_0400, 32'd0, 32'hCAFE_F00D, 2'b11, 0, 0, 2, 32'hCAFE_F00D);
        do_load(OP_LW,  32'h8000_0502, 32'd2, 32'hAABB_CCDD, 2'b00, 0, 0, 0, 32'h0000_AABB);

        //        op     awaddr         wdata          strb   aw w  b  br     post lit_wdata      err
        do_store(OP_SB, 32'h8000_0001, 32'h0000_00A5, 8'h02, 1, 0, 0, 2'b00, 0, 32'h0000_A500, 1'b0);
        do_store(OP_SW, 32'h8000_0000, 32'h1122_3344, 8'h0F, 0, 0, 0, 2'b10, 5, 32'h1122_3344, 1'b1);
        do_other();
        do_store(OP_SH, 32'h8000_0003, 32'h0000_BEEF, 8'h00, 2, 3, 1, 2'b00, 0, 32'hEF00_0000, 1'b0);
        do_other();

        // Abandon a load while waiting in R.
        exp_kind   = K_LOAD;
        exp_araddr = 32'h8000_0600;
        exp_rdata  = 32'd0;
        exp_err    = 1'b0;
        accept(INST_LOAD, OP_LW, 32'h8000_0600, 32'd0, 32'h0, 32'h0, 8'h0);
        wait_sig(0, lat);
        arready = 1'b1;
        @(posedge clk);
        #1;
        arready = 1'b0;
        wait_sig(1, lat);
        checki("rst_test_in_r", lat, 2);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst = 1'b1;

        do_load(OP_LB, 32'h8000_0700, 32'd0, 32'h0000_007F, 2'b00, 0, 0, 0, 32'h0000_007F);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200us required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dsram_post.md
# dsram_post

Load/store memory-access stage that sits directly downstream of the data-SRAM address/strobe preparation stage in the EXU. It latches a prepared load or store request, drives it onto an AXI4-Lite master port toward the data SRAM, waits for the response, and hands the result to the write-back stage. Loaded words are byte-aligned and sign- or zero-extended here. Non-memory instructions pass through without a bus transaction.

## Interface
Parameters: none. Widths come from `defines.v`: data and address 32 bits, `wstrb` 8 bits, with bits [7:4] always 0.

- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `valid_pre_i`  in  1  — upstream request valid.
- `ready_pre_o`  out  1  — stage can accept a request.
- `inst_type_i`  in  `INST_TYPE_BUS`  — `INST_LOAD`, `INST_STORE` or other.
- `lsu_op_i`  in  `LSU_OP_BUS`  — LB/LH/LW/LBU/LHU/SB/SH/SW.
- `araddr_i`, `roff_i`  in  32  — load address; byte offset, only [1:0] used.
- `awaddr_i`, `wdata_i`  in  32  — store address; unshifted store data.
- `wstrb_i`  in  8  — lane-aligned byte strobe.
- `valid_post_o`  out  1  — result valid to write-back.
- `ready_post_i`  in  1  — write-back accepts.
- `rdata_o`  out  32  — extended load result; 0 for stores and non-memory instructions.
- `err_o`  out  1  — bus error response for this request; valid only with `valid_post_o`.
- AXI4-Lite master:
  - `araddr` o32, `arvalid` o, `arready` i
  - `rdata` i32, `rresp` i2, `rvalid` i, `rready` o
  - `awaddr` o32, `awvalid` o, `awready` i
  - `wdata` o32, `wstrb` o8, `wvalid` o, `wready` i
  - `bresp` i2, `bvalid` i, `bready` o

## Operation
- **FSM states:** IDLE, AR, R, AW_W, B, DONE.
- **Output decode:** all handshake outputs decode from registered state and flags only. There is no input-to-output combinational path.
  - `ready_pre_o` = (IDLE)
  - `arvalid` = (AR)
  - `rready` = (R)
  - `awvalid` = (AW_W & !aw_done)
  - `wvalid` = (AW_W & !w_done)
  - `bready` = (B)
  - `valid_post_o` = (DONE)
- **IDLE:** on `valid_pre_i & ready_pre_o`, latch all request inputs. Next state is AR for `INST_LOAD`, AW_W for `INST_STORE`, DONE otherwise. Clear `aw_done`, `w_done` and the error flag.
- **AR:** on `arready`, go to R.
- **R:** on `rvalid`, latch the extended data and set error if `rresp != 0`, then go to DONE.
- **AW_W:**
  - `aw_done` sets on `awready`; `w_done` sets on `wready`. They are independent and may set in the same cycle.
  - Go to B in the cycle when both are done, counting handshakes that complete in that cycle.
- **B:** on `bvalid`, set error if `bresp != 0`, then go to DONE.
- **DONE:** on `ready_post_i`, go to IDLE. There is no same-cycle re-accept; a new request is taken one cycle later.
- **Store data:** `wdata` = `wdata_i << (8*awaddr_i[1:0])`. `wstrb` = `wstrb_i` unchanged.
- **Store with `wstrb_i == 0`** (misaligned SH/SW): the write is still issued with strobe 0.
- **Load extraction:** `sh = rdata >> (8*roff[1:0])`.
  - LB: sign-extend `sh[7:0]`.
  - LBU: zero-extend `sh[7:0]`.
  - LH: sign-extend `sh[15:0]`.
  - LHU: zero-extend `sh[15:0]`.
  - LW: `sh`.
  - Any other op: 0.
  - A misaligned load returns the shifted value; no exception is raised.
- **Output stability:**
  - AXI address, data and strobe outputs are held stable from the cycle valid rises until handshake.
  - `rdata_o` and `err_o` are held through DONE.

## Timing
- **Reset** (async assert, sync-released by the SoC):
  - State → IDLE.
  - All latched registers → 0.
  - Outputs: `ready_pre_o` = 1; every other output = 0.
- **Reset mid-transaction:** the transaction is abandoned immediately; no output glitches beyond the state reset.
- **Minimum latencies**, with accept at cycle 0 and slaves ready immediately:
  - Load: `arvalid` at 1, R at 2, `valid_post_o` at 3.
  - Store: `awvalid`/`wvalid` at 1, B at 2, `valid_post_o` at 3.
  - Non-memory: `valid_post_o` at 1.
- **Throughput:** one request per (latency + 1) cycles minimum.
- **Wait states:**
  - Arbitrary `arready`/`rvalid`/`awready`/`wready`/`bvalid` wait states are tolerated indefinitely.
  - Arbitrary backpressure on `ready_post_i` holds DONE with outputs stable.

## Test plan
- **LB with sign extension:** request LB with `araddr_i`=0x8000_0003, `roff_i`=3; slave returns `rdata`=0x80AB_CDEF → `rdata_o`=0xFFFF_FF80, `valid_post_o` at cycle 3, `err_o`=0.
- **LHU with delayed handshakes:** request LHU with `roff_i`=2, `rdata`=0x1234_5678, `arready` delayed 4 cycles → `rdata_o`=0x0000_1234; `araddr` held stable throughout.
- **SB with split handshakes:** request SB with `awaddr_i`=0x8000_0001, `wdata_i`=0x0000_00A5, `wstrb_i`=0x02; `wready` one cycle before `awready` → `wdata`=0x0000_A500, `wstrb`=0x02, `wvalid` drops after its handshake, B entered only after `awready`.
- **SW with error response and backpressure:** `bresp`=2'b10 → `err_o`=1 with `valid_post_o`; holding `ready_post_i`=0 for 5 cycles keeps DONE and outputs stable; the next request sees `err_o` cleared.
- **Non-memory instruction:** accepted → `valid_post_o` at cycle 1, `rdata_o`=0, no AXI valid ever asserted.
- **Reset asserted in R:** `rst` low while in R → immediately `ready_pre_o`=1, `rready`=0, `valid_post_o`=0, `rdata_o`=0.
